pattern_err_capture: RTL

PATTERN_ERR_CAPTURE -- requirements
Module: pattern_err_capture

---
 rtl/pattern_err_capture.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pattern_err_capture.sv
// Captures the first (or latest) pattern-checker mismatch across NCH channels
// and keeps a saturating error count per channel.
//
// state | meaning
// IDLE  | no unacknowledged error; err_valid=0
// HELD  | capture registers hold an error awaiting err_ack; err_valid=1
module pattern_err_capture #(
    parameter  int NCH  = 4,
    parameter  int DW   = 64,
    parameter  int CNTW = 16,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mode,
    input  logic [NCH-1:0]      err_strobe,
    input  logic [NCH*DW-1:0]   expc_bus,
    input  logic [NCH*DW-1:0]   rcvd_bus,
    input  logic                err_ack,
    input  logic                cnt_clr,
    output logic                err_valid,
    output logic [CHW-1:0]      err_ch,
    output logic [DW-1:0]       err_expc,
    output logic [DW-1:0]       err_rcvd,
    output logic [NCH*CNTW-1:0] err_cnt_bus,
    output logic                err_lost
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [DW-1:0]  expc_q, expc_d;
    logic [DW-1:0]  rcvd_q, rcvd_d;
    logic           lost_q, lost_d;
    logic           any_strobe;
    logic           capture;
    logic [CHW-1:0] lo_ch;
    logic [CNTW-1:0] cnt_q [NCH];

    // Priority pick: scanning downward leaves the lowest set index
    always_comb begin
        lo_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (err_strobe[i]) lo_ch = CHW'(i);
        end
    end

    assign any_strobe = |err_strobe;

    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_strobe) begin
                    capture = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (err_ack) begin
                    lost_d = 1'b0;
                    if (any_strobe) capture = 1'b1;
                    else            state_d = IDLE;
                end else if (any_strobe) begin
                    if (mode) capture = 1'b1;
                    else      lost_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_d   = ch_q;
        expc_d = expc_q;
        rcvd_d = rcvd_q;
        if (capture) begin
            ch_d   = lo_ch;
            expc_d = expc_bus[lo_ch*DW +: DW];
            rcvd_d = rcvd_bus[lo_ch*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            expc_q  <= '0;
            rcvd_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            expc_q  <= expc_d;
            rcvd_q  <= rcvd_d;
            lost_q  <= lost_d;
        end
    end

    // Counters run regardless of capture state; clear wins over a same-cycle strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cnt_clr)
                    cnt_q[i] <= '0;
                else if (err_strobe[i] && (cnt_q[i] != {CNTW{1'b1}}))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        err_cnt_bus = '0;
        for (int i = 0; i < NCH; i++) err_cnt_bus[i*CNTW +: CNTW] = cnt_q[i];
    end

    assign err_valid = (state_q == HELD);
    assign err_ch    = (NCH == 1) ? '0 : ch_q;
    assign err_expc  = expc_q;
    assign err_rcvd  = rcvd_q;
    assign err_lost  = lost_q;

endmodule
